// File: rtl/tis_fetch_sequencer_if.sv
// Fetch/execute bus of one TIS-100 node: the instruction ROM port, the
// execute-stage handshake and the debug PC.
// Optional macro TIS_FETCH_PERF_EN adds the retire/stall performance counters.
interface tis_fetch_sequencer_if #(
   parameter int ADDR_W  = 8,
   parameter int INSTR_W = 18
);
   logic [ADDR_W-1:0]  rom_addr;
   logic [INSTR_W-1:0] rom_data;
   logic [INSTR_W-1:0] instr;
   logic               instr_valid;
   logic               stall;
   logic               jmp_req;
   logic               jmp_rel;
   logic [ADDR_W-1:0]  jmp_target;
   logic               retire;
   logic [ADDR_W-1:0]  pc;
`ifdef TIS_FETCH_PERF_EN
   logic [15:0]        retire_count;
   logic [15:0]        stall_count;
`endif

   modport master (
      output rom_addr, instr, instr_valid, retire, pc,
`ifdef TIS_FETCH_PERF_EN
      output retire_count, stall_count,
`endif
      input  rom_data, stall, jmp_req, jmp_rel, jmp_target
   );

   modport slave (
      input  rom_addr, instr, instr_valid, retire, pc,
`ifdef TIS_FETCH_PERF_EN
      input  retire_count, stall_count,
`endif
      output rom_data, stall, jmp_req, jmp_rel, jmp_target
   );
endinterface

// File: rtl/tis_fetch_sequencer.sv
// Program sequencer for one TIS-100 node: owns the PC, addresses the
// instruction ROM, latches the fetched word for execute and retires it,
// applying sequential wrap, absolute jumps and clamped relative jumps.
// Optional macro TIS_FETCH_PERF_EN adds saturating retire/stall counters.
//
// state | meaning
// IDLE  | out of reset, waiting one edge before the first fetch
// FETCH | rom_addr = pc, word captured into instr at the edge
// EXEC  | instr valid; held while stalled, retires when stall=0
module tis_fetch_sequencer #(
   parameter int ADDR_W   = 8,
   parameter int INSTR_W  = 18,
   parameter int PROG_LEN = 26
) (
   input  logic                   clk,
   input  logic                   reset,
   tis_fetch_sequencer_if.master  bus
);
   typedef enum logic [1:0] {IDLE, FETCH, EXEC} state_t;

   localparam logic [ADDR_W-1:0]        LAST_A = ADDR_W'(PROG_LEN - 1);
   localparam logic [ADDR_W:0]          LEN_X  = (ADDR_W + 1)'(PROG_LEN);
   localparam logic signed [ADDR_W+1:0] LAST_S = (ADDR_W + 2)'(PROG_LEN - 1);

   state_t                   state;
   logic [ADDR_W-1:0]        pc_q;
   logic [INSTR_W-1:0]       instr_q;
   logic                     valid_q;
   logic                     retire_c;
   logic [ADDR_W-1:0]        next_pc;
   logic signed [ADDR_W+1:0] rel_sum;

   // Retirement is the unstalled EXEC cycle; it must not wait a clock.
   assign retire_c = (state == EXEC) && !bus.stall;

   // Relative target at two extra bits so both underflow and overflow are visible.
   assign rel_sum = $signed({2'b00, pc_q}) +
                    $signed({{2{bus.jmp_target[ADDR_W-1]}}, bus.jmp_target});

   // Next PC selection; targets outside the program are folded back into it.
   always_comb begin
      next_pc = '0;
      if (!bus.jmp_req) begin
         next_pc = (pc_q == LAST_A) ? '0 : pc_q + 1'b1;
      end else if (!bus.jmp_rel) begin
         next_pc = ({1'b0, bus.jmp_target} < LEN_X) ? bus.jmp_target : '0;
      end else if (rel_sum < 0) begin
         next_pc = '0;
      end else if (rel_sum > LAST_S) begin
         next_pc = LAST_A;
      end else begin
         next_pc = rel_sum[ADDR_W-1:0];
      end
   end

   // Fetch/execute FSM; pc only moves on retirement so rom_addr is stable in EXEC.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         pc_q    <= '0;
         instr_q <= '0;
         valid_q <= 1'b0;
      end else begin
         case (state)
            IDLE: state <= FETCH;
            FETCH: begin
               instr_q <= bus.rom_data;
               valid_q <= 1'b1;
               state   <= EXEC;
            end
            EXEC: begin
               if (!bus.stall) begin
                  pc_q    <= next_pc;
                  valid_q <= 1'b0;
                  state   <= FETCH;
               end
            end
            default: begin
               valid_q <= 1'b0;
               state   <= IDLE;
            end
         endcase
      end
   end

   assign bus.rom_addr    = pc_q;
   assign bus.pc          = pc_q;
   assign bus.instr       = instr_q;
   assign bus.instr_valid = valid_q;
   assign bus.retire      = retire_c;

`ifdef TIS_FETCH_PERF_EN
   logic [15:0] retire_cnt_q;
   logic [15:0] stall_cnt_q;

   // Saturating counters of retirements and stalled EXEC cycles.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         retire_cnt_q <= '0;
         stall_cnt_q  <= '0;
      end else begin
         if (retire_c && retire_cnt_q != 16'hFFFF)
            retire_cnt_q <= retire_cnt_q + 16'd1;
         if (state == EXEC && bus.stall && stall_cnt_q != 16'hFFFF)
            stall_cnt_q <= stall_cnt_q + 16'd1;
      end
   end

   assign bus.retire_count = retire_cnt_q;
   assign bus.stall_count  = stall_cnt_q;
`endif
endmodule

// File: tb/tb_tis_fetch_sequencer.sv
// Bench for tis_fetch_sequencer: random ROM image, directed scenarios and
// randomized instruction streams checked against an arithmetic PC model.
module tb_tis_fetch_sequencer;
   localparam int LEN = 26;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   failures = 0;
   int   exp_pc = 0;
   logic [17:0] rom [LEN];

   tis_fetch_sequencer_if #(.ADDR_W(8), .INSTR_W(18)) bus ();

   tis_fetch_sequencer #(.ADDR_W(8), .INSTR_W(18), .PROG_LEN(LEN)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.master)
   );

   always #5 clk = ~clk;

   assign bus.rom_data = (int'(bus.rom_addr) < LEN) ? rom[bus.rom_addr] : 18'h0;

   // Program-counter rules expressed as plain integer arithmetic.
   function automatic int model_next(int p, bit jq, bit jr, logic [7:0] t);
      int s;
      if (!jq) return (p == LEN - 1) ? 0 : p + 1;
      if (!jr) return (int'(t) < LEN) ? int'(t) : 0;
      s = p + int'($signed(t));
      if (s < 0) return 0;
      if (s > LEN - 1) return LEN - 1;
      return s;
   endfunction

   // One instruction: entered at a negedge in FETCH, left at the negedge after retirement.
   task automatic step(int ns, bit sjq, bit sjr, logic [7:0] st,
                       bit jq, bit jr, logic [7:0] jt);
`ifdef TIS_FETCH_PERF_EN
      logic [15:0] sc0, rc0;
`endif
      checks++;
      if (bus.instr_valid !== 1'b0) begin
         failures++; $display("FAIL fetch_valid got=%0b exp=0", bus.instr_valid);
      end
      checks++;
      if (bus.rom_addr !== 8'(exp_pc)) begin
         failures++; $display("FAIL fetch_addr got=%0d exp=%0d", bus.rom_addr, exp_pc);
      end
      checks++;
      if (bus.retire !== 1'b0) begin
         failures++; $display("FAIL fetch_retire got=%0b exp=0", bus.retire);
      end
      @(negedge clk);
      checks++;
      if (bus.instr_valid !== 1'b1) begin
         failures++; $display("FAIL exec_valid got=%0b exp=1", bus.instr_valid);
      end
      checks++;
      if (bus.instr !== rom[exp_pc]) begin
         failures++; $display("FAIL exec_instr pc=%0d got=%0h exp=%0h", exp_pc, bus.instr, rom[exp_pc]);
      end
      checks++;
      if (bus.pc !== 8'(exp_pc)) begin
         failures++; $display("FAIL exec_pc got=%0d exp=%0d", bus.pc, exp_pc);
      end
`ifdef TIS_FETCH_PERF_EN
      sc0 = bus.stall_count;
      rc0 = bus.retire_count;
`endif
      for (int i = 0; i < ns; i++) begin
         bus.stall = 1'b1; bus.jmp_req = sjq; bus.jmp_rel = sjr; bus.jmp_target = st;
         #1;
         checks++;
         if (bus.retire !== 1'b0) begin
            failures++; $display("FAIL stall_retire got=%0b exp=0", bus.retire);
         end
         @(negedge clk);
         checks++;
         if (bus.instr !== rom[exp_pc] || bus.pc !== 8'(exp_pc) || bus.instr_valid !== 1'b1
             || bus.rom_addr !== 8'(exp_pc)) begin
            failures++;
            $display("FAIL stall_hold got pc=%0d addr=%0d instr=%0h valid=%0b exp pc=%0d instr=%0h valid=1",
                     bus.pc, bus.rom_addr, bus.instr, bus.instr_valid, exp_pc, rom[exp_pc]);
         end
      end
      bus.stall = 1'b0; bus.jmp_req = jq; bus.jmp_rel = jr; bus.jmp_target = jt;
      #1;
      checks++;
      if (bus.retire !== 1'b1) begin
         failures++; $display("FAIL retire_pulse got=%0b exp=1", bus.retire);
      end
      @(negedge clk);
      bus.jmp_req = 1'b0; bus.jmp_rel = 1'b0; bus.jmp_target = 8'h0;
`ifdef TIS_FETCH_PERF_EN
      checks++;
      if (bus.stall_count !== sc0 + 16'(ns)) begin
         failures++; $display("FAIL stall_count got=%0d exp=%0d", bus.stall_count, sc0 + 16'(ns));
      end
      checks++;
      if (bus.retire_count !== rc0 + 16'd1) begin
         failures++; $display("FAIL retire_count got=%0d exp=%0d", bus.retire_count, rc0 + 16'd1);
      end
`endif
      exp_pc = model_next(exp_pc, jq, jr, jt);
   endtask

   task automatic goto_pc(int target);
      step(0, 0, 0, 8'h0, 1, 0, 8'(target));
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.stall = 1'b0; bus.jmp_req = 1'b0; bus.jmp_rel = 1'b0; bus.jmp_target = 8'h0;
      #1;
      checks++;
      if (bus.pc !== 8'h0 || bus.rom_addr !== 8'h0 || bus.instr !== 18'h0
          || bus.instr_valid !== 1'b0 || bus.retire !== 1'b0) begin
         failures++;
         $display("FAIL reset_values got pc=%0d addr=%0d instr=%0h valid=%0b retire=%0b exp all 0",
                  bus.pc, bus.rom_addr, bus.instr, bus.instr_valid, bus.retire);
      end
`ifdef TIS_FETCH_PERF_EN
      checks++;
      if (bus.retire_count !== 16'h0 || bus.stall_count !== 16'h0) begin
         failures++; $display("FAIL reset_counts got r=%0d s=%0d exp 0", bus.retire_count, bus.stall_count);
      end
`endif
      @(negedge clk);
      reset = 1'b0;
      exp_pc = 0;
      @(negedge clk);
   endtask

   task automatic test_sequential();
      for (int k = 0; k < LEN + 2; k++) step(0, 0, 0, 8'h0, 0, 0, 8'h0);
   endtask

   task automatic test_stall();
      goto_pc(5);
      step(4, 0, 0, 8'h0, 0, 0, 8'h0);
      checks++;
      if (bus.rom_addr !== 8'd6) begin
         failures++; $display("FAIL stall_next_addr got=%0d exp=6", bus.rom_addr);
      end
   endtask

   task automatic test_abs_jump();
      goto_pc(3);
      step(0, 0, 0, 8'h0, 1, 0, 8'd20);
      goto_pc(3);
      step(0, 0, 0, 8'h0, 1, 0, 8'd30);
      checks++;
      if (bus.rom_addr !== 8'd0) begin
         failures++; $display("FAIL abs_out_of_range got=%0d exp=0", bus.rom_addr);
      end
   endtask

   task automatic test_rel_jump();
      goto_pc(10);
      step(0, 0, 0, 8'h0, 1, 1, 8'hFD);
      goto_pc(2);
      step(0, 0, 0, 8'h0, 1, 1, 8'hF6);
      goto_pc(20);
      step(0, 0, 0, 8'h0, 1, 1, 8'h0A);
      checks++;
      if (bus.rom_addr !== 8'd25) begin
         failures++; $display("FAIL rel_clamp_high got=%0d exp=25", bus.rom_addr);
      end
      goto_pc(4);
      step(0, 0, 0, 8'h0, 1, 1, 8'h00);
      step(0, 0, 0, 8'h0, 0, 0, 8'h0);
   endtask

   task automatic test_stall_jump();
      goto_pc(8);
      step(3, 1, 0, 8'd15, 0, 0, 8'h0);
      checks++;
      if (bus.rom_addr !== 8'd9) begin
         failures++; $display("FAIL stall_beats_jump got=%0d exp=9", bus.rom_addr);
      end
   endtask

   task automatic test_reset_mid();
      goto_pc(12);
      @(negedge clk);
      bus.stall = 1'b1;
      #2 reset = 1'b1;
      #1;
      checks++;
      if (bus.pc !== 8'h0 || bus.rom_addr !== 8'h0 || bus.instr !== 18'h0
          || bus.instr_valid !== 1'b0 || bus.retire !== 1'b0) begin
         failures++;
         $display("FAIL reset_async got pc=%0d addr=%0d instr=%0h valid=%0b retire=%0b exp all 0",
                  bus.pc, bus.rom_addr, bus.instr, bus.instr_valid, bus.retire);
      end
      @(negedge clk);
      reset = 1'b0;
      bus.stall = 1'b0;
      exp_pc = 0;
      @(negedge clk);
      for (int k = 0; k < 3; k++) step(0, 0, 0, 8'h0, 0, 0, 8'h0);
   endtask

   task automatic test_random();
      for (int k = 0; k < 60; k++) begin
         int ns;
         bit jq, jr;
         logic [7:0] jt;
         ns = $urandom_range(0, 3);
         jq = ($urandom_range(0, 2) != 0);
         jr = $urandom_range(0, 1);
         jt = jr ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 40));
         step(ns, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
              jq, jr, jt);
      end
   endtask

   initial begin
      for (int a = 0; a < LEN; a++) rom[a] = 18'($urandom);
      test_reset();
      test_sequential();
      test_stall();
      test_abs_jump();
      test_rel_jump();
      test_stall_jump();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
